// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM arbiter ports: phase indices, FSM states,
// fixed byte-enable / fill constants and write byte-lane formatting.
package dram_pkg;

    // Bit positions of the c0..c3 phase strobes inside a packed {c3,c2,c1,c0} vector
    localparam int unsigned PH_C0 = 0;
    localparam int unsigned PH_C1 = 1;
    localparam int unsigned PH_C2 = 2;
    localparam int unsigned PH_C3 = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RD_WAIT,
        ST_DONE
    } dram_state_e;

    // Reads always fetch the whole word
    localparam logic [1:0]  BSEL_RD = 2'b11;
    // Value returned when a read never completes
    localparam logic [15:0] RD_FILL = 16'hFFFF;

    // Byte enable for a single-byte write: high byte selects lane 1
    function automatic logic [1:0] wr_bsel(input logic hi);
        return hi ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dram_rd_timer.sv
// Read-completion watchdog: cleared on load, counts while enabled, and flags
// expiry on the clk where the count reaches TIMEOUT.
module dram_rd_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Expiry is flagged on the enabled clk whose increment would reach TIMEOUT
    always_comb begin
        expire_o = en_i && (cnt_q == LAST);
    end

    // Count enabled clks since the last load; hold once expired
    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dram_cpu_port.sv
// CPU-side responder of the DRAM arbiter: grants CPU accesses into free
// 4-phase slots, issues one DRAM command per grant and returns read words
// with strobe/latch timing. A read that never returns completes with RD_FILL
// and raises a sticky error.
module dram_cpu_port
    import dram_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = 15,
    parameter int unsigned ADDR_W     = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0,
    input  logic              c1,
    input  logic              c2,
    input  logic              c3,
    input  logic              vid_claim,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wrbsel,
    input  logic [7:0]        cpu_wrdata,
    output logic              cpu_next,
    output logic              cpu_strobe,
    output logic              cpu_latch,
    output logic [15:0]       cpu_rddata,
    output logic              cpu_err,
    output logic              dram_cmd,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_we,
    output logic [1:0]        dram_bsel,
    output logic [15:0]       dram_wrdata,
    input  logic              dram_rdvalid,
    input  logic [15:0]       dram_rddata
);

    dram_state_e       state_q;
    logic              cpu_next_q;
    logic              cpu_strobe_q;
    logic              cpu_latch_q;
    logic [15:0]       cpu_rddata_q;
    logic              cpu_err_q;
    logic              dram_cmd_q;
    logic [ADDR_W-1:0] dram_addr_q;
    logic              dram_we_q;
    logic [1:0]        dram_bsel_q;
    logic [15:0]       dram_wrdata_q;

    logic [3:0] phase;
    logic       slot_free;
    logic       grant;
    logic       tmr_load;
    logic       tmr_en;
    logic       rd_expire;
    logic       rd_done;

    // Slot bookkeeping: who may grant this clk and whether a read finishes now
    always_comb begin
        phase     = {c3, c2, c1, c0};
        slot_free = (state_q == ST_IDLE) || (state_q == ST_DONE);
        grant     = phase[PH_C3] && cpu_req && cpu_next_q && slot_free;
        tmr_load  = (state_q == ST_ISSUE) && phase[PH_C0];
        tmr_en    = (state_q == ST_RD_WAIT);
        rd_done   = tmr_en && (dram_rdvalid || rd_expire);
    end

    dram_rd_timer #(
        .TIMEOUT (RD_TIMEOUT)
    ) u_rd_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .expire_o (rd_expire)
    );

    // Phase strobes must stay one-hot while running
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot(phase));
        end
    end

    // Access FSM with all CPU- and DRAM-facing outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cpu_next_q    <= 1'b1;
            cpu_strobe_q  <= 1'b0;
            cpu_latch_q   <= 1'b0;
            cpu_rddata_q  <= RD_FILL;
            cpu_err_q     <= 1'b0;
            dram_cmd_q    <= 1'b0;
            dram_addr_q   <= '0;
            dram_we_q     <= 1'b0;
            dram_bsel_q   <= '0;
            dram_wrdata_q <= '0;
        end else begin
            dram_cmd_q   <= 1'b0;
            cpu_strobe_q <= 1'b0;

            // A read finishing on this c2 still frees the slot for the coming c3
            if (phase[PH_C2]) begin
                cpu_next_q <= !vid_claim && (slot_free || rd_done);
            end

            // A grant on c3 defers the latch clear to its ISSUE clk
            if (phase[PH_C3] && !grant) begin
                cpu_latch_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (grant) begin
                        state_q       <= ST_ISSUE;
                        dram_addr_q   <= cpu_addr;
                        dram_we_q     <= !cpu_rnw;
                        dram_bsel_q   <= cpu_rnw ? BSEL_RD : wr_bsel(cpu_wrbsel);
                        dram_wrdata_q <= {2{cpu_wrdata}};
                    end else if (phase[PH_C3]) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (phase[PH_C0]) begin
                        dram_cmd_q  <= 1'b1;
                        cpu_latch_q <= 1'b0;
                        state_q     <= dram_we_q ? ST_DONE : ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_done) begin
                        cpu_strobe_q <= 1'b1;
                        cpu_latch_q  <= 1'b1;
                        state_q      <= ST_DONE;
                        if (dram_rdvalid) begin
                            cpu_rddata_q <= dram_rddata;
                        end else begin
                            cpu_rddata_q <= RD_FILL;
                            cpu_err_q    <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_next    = cpu_next_q;
    assign cpu_strobe  = cpu_strobe_q;
    assign cpu_latch   = cpu_latch_q;
    assign cpu_rddata  = cpu_rddata_q;
    assign cpu_err     = cpu_err_q;
    assign dram_cmd    = dram_cmd_q;
    assign dram_addr   = dram_addr_q;
    assign dram_we     = dram_we_q;
    assign dram_bsel   = dram_bsel_q;
    assign dram_wrdata = dram_wrdata_q;

endmodule
